// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the alu_muldiv execute-stage unit.
package alu_pkg;

  localparam int unsigned OpW = 5;

  typedef enum logic [OpW-1:0] {
    OpAnd    = 5'b00000,
    OpOr     = 5'b00001,
    OpAdd    = 5'b00010,
    OpSlt    = 5'b00011,
    OpSltu   = 5'b00100,
    OpSll    = 5'b00101,
    OpSub    = 5'b00110,
    OpSrl    = 5'b00111,
    OpEq     = 5'b01000,
    OpXor    = 5'b01001,
    OpSra    = 5'b01010,
    OpMul    = 5'b10000,
    OpMulh   = 5'b10001,
    OpMulhsu = 5'b10010,
    OpMulhu  = 5'b10011,
    OpDiv    = 5'b10100,
    OpDivu   = 5'b10101,
    OpRem    = 5'b10110,
    OpRemu   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } alu_state_e;

  // Only 10xxx codes are M ops; 11xxx codes are undefined and take the base path.
  function automatic logic is_mop(input logic [OpW-1:0] op);
    return op[OpW-1:OpW-2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Issue/result bundle between the execute stage and alu_muldiv.
interface alu_muldiv_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 5
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    ALUResult;
  logic                     out_valid;

  modport master (
    output flush, in_valid, SrcA, SrcB, Operation,
    input  in_ready, ALUResult, out_valid
  );

  modport slave (
    input  flush, in_valid, SrcA, SrcB, Operation,
    output in_ready, ALUResult, out_valid
  );
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply (shift-add) / restoring divide datapath on operand magnitudes.
module muldiv_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  step_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] res_o
);
  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  logic [W-1:0]    acc_q, acc_d, sreg_q, sreg_d, opnd_q, opnd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_div_q, is_div_d, hi_q, hi_d, rem_sel_q, rem_sel_d;
  logic            neg_q, neg_d, rneg_q, rneg_d, bzero_q, bzero_d;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag, acc_step, sreg_step;
  logic [W:0]      mul_sum, div_diff;
  logic [2*W-1:0]  prod, prod_c;

  assign a_neg = a_i[W-1] & (op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11));
  assign b_neg = b_i[W-1] & (op_i[2] ? ~op_i[0] : ~op_i[1]);
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // mul: {acc, sreg} is the running product; div: acc is remainder, sreg dividend/quotient.
  assign mul_sum  = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, opnd_q} : '0);
  assign div_diff = {acc_q, sreg_q[W-1]} - {1'b0, opnd_q};

  always_comb begin
    acc_step  = mul_sum[W:1];
    sreg_step = {mul_sum[0], sreg_q[W-1:1]};
    if (is_div_q) begin
      if (!div_diff[W]) begin
        acc_step  = div_diff[W-1:0];
        sreg_step = {sreg_q[W-2:0], 1'b1};
      end else begin
        acc_step  = {acc_q[W-2:0], sreg_q[W-1]};
        sreg_step = {sreg_q[W-2:0], 1'b0};
      end
    end
  end

  assign prod   = {acc_step, sreg_step};
  assign prod_c = neg_q ? -prod : prod;
  assign last_o = (cnt_q == '0);

  // Division by zero keeps the all-ones quotient regardless of dividend sign.
  always_comb begin
    res_o = hi_q ? prod_c[2*W-1:W] : prod_c[W-1:0];
    if (is_div_q) begin
      if (rem_sel_q) res_o = rneg_q ? -acc_step : acc_step;
      else           res_o = (neg_q && !bzero_q) ? -sreg_step : sreg_step;
    end
  end

  always_comb begin
    acc_d     = acc_q;
    sreg_d    = sreg_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    rem_sel_d = rem_sel_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    bzero_d   = bzero_q;
    if (start_i) begin
      is_div_d  = op_i[2];
      hi_d      = (op_i[1:0] != 2'b00);
      rem_sel_d = op_i[1];
      neg_d     = a_neg ^ b_neg;
      rneg_d    = a_neg;
      bzero_d   = (b_i == '0);
      acc_d     = '0;
      opnd_d    = op_i[2] ? b_mag : a_mag;
      sreg_d    = op_i[2] ? a_mag : b_mag;
      cnt_d     = CntW'(W - 1);
    end else if (step_i) begin
      acc_d  = acc_step;
      sreg_d = sreg_step;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      sreg_q    <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      hi_q      <= 1'b0;
      rem_sel_q <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      bzero_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sreg_q    <= sreg_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      rem_sel_q <= rem_sel_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      bzero_q   <= bzero_d;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle ALU: single-cycle base ops plus iterative RV32M ops behind a valid/ready issue port.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 5
) (
  input logic         clk,
  input logic         reset,
  alu_muldiv_if.slave bus
);
  localparam int unsigned ShW = $clog2(DATA_WIDTH);

  alu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d, base_res, md_res;
  logic                  out_valid_q, out_valid_d;
  logic                  md_start, md_step, md_last;
  logic [ShW-1:0]        shamt;
  alu_op_e               op;

  assign op    = alu_op_e'(bus.Operation[OpW-1:0]);
  assign shamt = bus.SrcB[ShW-1:0];

  always_comb begin
    base_res = '0;
    unique case (op)
      OpAnd:   base_res = bus.SrcA & bus.SrcB;
      OpOr:    base_res = bus.SrcA | bus.SrcB;
      OpAdd:   base_res = bus.SrcA + bus.SrcB;
      OpSlt:   base_res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
      OpSltu:  base_res = {{(DATA_WIDTH-1){1'b0}}, bus.SrcA < bus.SrcB};
      OpSll:   base_res = bus.SrcA << shamt;
      OpSub:   base_res = bus.SrcA - bus.SrcB;
      OpSrl:   base_res = bus.SrcA >> shamt;
      OpEq:    base_res = {{(DATA_WIDTH-1){1'b0}}, bus.SrcA == bus.SrcB};
      OpXor:   base_res = bus.SrcA ^ bus.SrcB;
      OpSra:   base_res = $signed(bus.SrcA) >>> shamt;
      default: base_res = '0;
    endcase
  end

  muldiv_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start_i(md_start),
    .step_i (md_step),
    .op_i   (bus.Operation[2:0]),
    .a_i    (bus.SrcA),
    .b_i    (bus.SrcB),
    .last_o (md_last),
    .res_o  (md_res)
  );

  assign md_step = (state_q == StBusy) && !bus.flush;

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    md_start    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && !bus.flush) begin
          if (is_mop(bus.Operation[OpW-1:0])) begin
            md_start = 1'b1;
            state_d  = StBusy;
          end else begin
            result_d    = base_res;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end
        end
      end
      StBusy: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (md_last) begin
          result_d    = md_res;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.ALUResult = result_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed and randomized checks of alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  int           tests = 0;
  int           failed = 0;
  int           pulses = 0;
  int           p0;
  int           n;
  int           lat;
  logic [W-1:0] prev;
  logic [4:0]   hs_op [4];
  logic [W-1:0] hs_a  [4];
  logic [W-1:0] hs_b  [4];
  logic [4:0]   rnd_ops [22];

  alu_muldiv_if #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) bus ();

  alu_muldiv #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.out_valid) pulses <= pulses + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic [63:0]     p;
    case (op)
      OpAnd:    return a & b;
      OpOr:     return a | b;
      OpAdd:    return a + b;
      OpSlt:    return (sa < sb) ? 1 : 0;
      OpSltu:   return (ua < ub) ? 1 : 0;
      OpSll:    return a << b[4:0];
      OpSub:    return a - b;
      OpSrl:    return a >> b[4:0];
      OpEq:     return (a == b) ? 1 : 0;
      OpXor:    return a ^ b;
      OpSra:    return $signed(a) >>> b[4:0];
      OpMul:    begin p = ua * ub; return p[31:0]; end
      OpMulh:   begin p = sa * sb; return p[63:32]; end
      OpMulhsu: begin p = sa * longint'(ub); return p[63:32]; end
      OpMulhu:  begin p = ua * ub; return p[63:32]; end
      OpDiv: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        p = sa / sb;
        return p[31:0];
      end
      OpDivu:   return (b == 0) ? '1 : a / b;
      OpRem: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == '1) return 0;
        p = sa % sb;
        return p[31:0];
      end
      OpRemu:   return (b == 0) ? a : a % b;
      default:  return 0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] op);
    return (op[4:3] == 2'b10) ? W + 1 : 1;
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 1;
      2:       return '1;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.in_ready && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    logic [W-1:0] exp;
    int           l;
    int           rdy_hi;
    exp = model(op, a, b);
    wait_ready();
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    l      = 1;
    rdy_hi = 0;
    while (!bus.out_valid && l < 60) begin
      if (bus.in_ready) rdy_hi++;
      tick();
      l++;
    end
    check({tag, " latency"}, W'(l), W'(exp_lat(op)));
    check({tag, " result"}, bus.ALUResult, exp);
    check({tag, " ready_done"}, W'(bus.in_ready), 0);
    if (exp_lat(op) > 1) check({tag, " ready_busy"}, W'(rdy_hi), 0);
    tick();
    check({tag, " pulse_len"}, W'(bus.out_valid), 0);
    check({tag, " ready_after"}, W'(bus.in_ready), 1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    bus.Operation = '0;
    #1;
    check("rst result", bus.ALUResult, 0);
    check("rst out_valid", W'(bus.out_valid), 0);
    check("rst in_ready", W'(bus.in_ready), 1);
    #20;
    @(negedge clk);
    reset = 1'b0;
    tick();
    do_op(OpAdd, 32'd1, 32'd1, "add 1+1");

    // Reset in the middle of a DIV
    wait_ready();
    bus.Operation = OpDiv;
    bus.SrcA      = 32'd100;
    bus.SrcB      = 32'd3;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    p0    = pulses;
    reset = 1'b1;
    #1;
    check("midrst result", bus.ALUResult, 0);
    check("midrst out_valid", W'(bus.out_valid), 0);
    check("midrst in_ready", W'(bus.in_ready), 1);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) tick();
    check("midrst no pulse", W'(pulses - p0), 0);
    do_op(OpAdd, 32'd3, 32'd4, "add 3+4");

    do_op(OpSub, 32'd5, 32'd7, "sub");
    do_op(OpSlt, 32'hFFFF_FFFF, 32'd1, "slt");
    do_op(OpSltu, 32'hFFFF_FFFF, 32'd1, "sltu");
    do_op(OpSra, 32'h8000_0000, 32'd4, "sra");
    do_op(OpEq, 32'd9, 32'd9, "eq");
    do_op(5'b11111, 32'd9, 32'd9, "undef");

    do_op(OpMul, -32'sd3, 32'd7, "mul");
    do_op(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    do_op(OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
    do_op(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");

    do_op(OpDiv, -32'sd7, 32'd2, "div");
    do_op(OpRem, -32'sd7, 32'd2, "rem");
    do_op(OpDivu, 32'd7, 32'd0, "divu0");
    do_op(OpRemu, 32'd7, 32'd0, "remu0");
    do_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    do_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");

    // Back-to-back issue with in_valid held high
    hs_op = '{OpMul, OpAdd, OpDivu, OpXor};
    hs_a  = '{32'd123, 32'd10, 32'd1000, 32'hF0F0_F0F0};
    hs_b  = '{32'd456, 32'd20, 32'd7, 32'h0FF0_0FF0};
    p0    = pulses;
    bus.Operation = hs_op[0];
    bus.SrcA      = hs_a[0];
    bus.SrcB      = hs_b[0];
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      tick();
      if (i < 3) begin
        bus.Operation = hs_op[i+1];
        bus.SrcA      = hs_a[i+1];
        bus.SrcB      = hs_b[i+1];
      end else begin
        bus.in_valid = 1'b0;
      end
      lat = 1;
      while (!bus.out_valid && lat < 60) begin
        tick();
        lat++;
      end
      check("hs latency", W'(lat), W'(exp_lat(hs_op[i])));
      check("hs result", bus.ALUResult, model(hs_op[i], hs_a[i], hs_b[i]));
    end
    repeat (40) tick();
    check("hs pulse count", W'(pulses - p0), 4);

    // Flush in BUSY cycle 10
    prev = model(hs_op[3], hs_a[3], hs_b[3]);
    wait_ready();
    bus.Operation = OpDiv;
    bus.SrcA      = 32'd100;
    bus.SrcB      = 32'd7;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    p0        = pulses;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush in_ready", W'(bus.in_ready), 1);
    check("flush out_valid", W'(bus.out_valid), 0);
    check("flush result", bus.ALUResult, prev);
    repeat (40) tick();
    check("flush no pulse", W'(pulses - p0), 0);

    // Flush while idle blocks acceptance
    bus.Operation = OpAdd;
    bus.SrcA      = 32'd50;
    bus.SrcB      = 32'd60;
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("idle flush ready", W'(bus.in_ready), 1);
    check("idle flush valid", W'(bus.out_valid), 0);
    do_op(OpAdd, 32'd11, 32'd22, "add post flush");

    rnd_ops = '{OpAnd, OpOr, OpAdd, OpSlt, OpSltu, OpSll, OpSub, OpSrl, OpEq, OpXor, OpSra,
                OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu,
                5'b11111, 5'b01011, 5'b11000};
    for (int i = 0; i < 60; i++) begin
      do_op(rnd_ops[$urandom_range(0, 21)], rnd_opnd(), rnd_opnd(), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
